// File: rtl/ex3_pkg.sv
// Shared types and constants for the Excess-3 frame to binary converter.
package ex3_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } ex3_state_e;

    localparam int         OUT_W        = 14;
    localparam logic [3:0] EX3_OFFSET   = 4'd3;
    // Codes outside [EX3_CODE_MIN, EX3_CODE_MAX] are invalid (0000..0010, 1101..1111).
    localparam logic [3:0] EX3_CODE_MIN = 4'b0011;
    localparam logic [3:0] EX3_CODE_MAX = 4'b1100;

    function automatic logic ex3_is_invalid(input logic [3:0] code);
        return (code < EX3_CODE_MIN) || (code > EX3_CODE_MAX);
    endfunction

endpackage

// File: rtl/ex3_digit_dec.sv
// Combinational Excess-3 digit decoder: invalid codes map to digit 0 with a flag.
module ex3_digit_dec
    import ex3_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [3:0] o_digit,
    output logic       o_invalid
);

    logic w_invalid;

    assign w_invalid = ex3_is_invalid(i_code);
    assign o_invalid = w_invalid;
    assign o_digit   = w_invalid ? 4'd0 : (i_code - EX3_OFFSET);

endmodule

// File: rtl/ex3_to_bin.sv
// Accumulates up to NDIG Excess-3 digits (MSD first) into a binary value and
// holds the result until consumed. Define EX3_ERR_CNT_EN to add the err_cnt port.
// Handshake: a digit is taken on in_valid && in_ready; a result is taken on
// out_valid && out_ready. dbg_state exposes the FSM state for checkers.
module ex3_to_bin
    import ex3_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_digit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_bin,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output ex3_state_e       dbg_state
`ifdef EX3_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    ex3_state_e       r_state;
    ex3_state_e       w_state_nxt;
    logic [OUT_W-1:0] r_acc;
    logic             r_err;
    logic [2:0]       r_cnt;

    logic [3:0]       w_digit;
    logic             w_invalid;
    logic             w_accept;
    logic             w_final;
    logic             w_consume;
    logic [OUT_W-1:0] w_acc_nxt;

    ex3_digit_dec u_dec (
        .i_code    (in_digit),
        .o_digit   (w_digit),
        .o_invalid (w_invalid)
    );

    assign w_accept  = in_valid && (r_state == COLLECT);
    // The NDIG-th digit closes the frame whatever in_last says.
    assign w_final   = w_accept && (in_last || (r_cnt == 3'(NDIG - 1)));
    assign w_consume = (r_state == HOLD) && out_ready;
    assign w_acc_nxt = (r_acc << 3) + (r_acc << 1) + OUT_W'(w_digit);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_final)   w_state_nxt = HOLD;
            HOLD:    if (out_ready) w_state_nxt = COLLECT;
            default:                w_state_nxt = COLLECT;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bin   = '0;
        out_err   = 1'b0;
        case (r_state)
            COLLECT: in_ready = 1'b1;
            HOLD: begin
                out_valid = 1'b1;
                out_bin   = r_acc;
                out_err   = r_err;
            end
            default: in_ready = 1'b1;
        endcase
    end

    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (w_consume) begin
            r_acc <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
            r_err <= r_err | w_invalid;
            r_cnt <= r_cnt + 3'd1;
        end
    end

`ifdef EX3_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Lifetime count of invalid digits; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_invalid && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: doc/ex3_to_bin.md
EX3_TO_BIN -- requirements
Module: ex3_to_bin

Interface
REQ-001 SHALL have parameter NDIG, default 4, meaning maximum Excess-3 digits per frame; legal range 1..4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_digit, input, 4, one Excess-3 coded digit, most significant digit first.
REQ-005 SHALL have port in_valid, input, 1, in_digit is valid this cycle.
REQ-006 SHALL have port in_last, input, 1, qualified by in_valid; marks the final digit of a frame.
REQ-007 SHALL have port in_ready, output, 1, block accepts a digit this cycle.
REQ-008 SHALL have port out_bin, output, 14, binary value of the completed frame (0..9999).
REQ-009 SHALL have port out_err, output, 1, the frame contained at least one invalid code.
REQ-010 SHALL have port out_valid, output, 1, out_bin/out_err hold a completed frame.
REQ-011 SHALL have port out_ready, input, 1, downstream consumes the result.

Function
REQ-012 Digit accept SHALL occur when in_valid && in_ready; no other cycle changes the accumulator.
REQ-013 Valid codes 0011..1100 SHALL decode to digit = code - 3 (0..9).
REQ-014 Invalid codes 0000, 0001, 0010, 1101, 1110, 1111 SHALL decode as digit 0 and set the frame error flag.
REQ-015 On each accept, acc SHALL update to acc*10 + digit, 14 bits, no truncation possible.
REQ-016 FSM states SHALL be COLLECT and HOLD only.
REQ-017 COLLECT: in_ready=1, out_valid=0; digit counter increments per accept.
REQ-018 COLLECT->HOLD when accepting a digit with in_last=1 or the NDIG-th digit; the in_last value on the NDIG-th digit is ignored.
REQ-019 HOLD: in_ready=0, out_valid=1; out_bin and out_err stable until consumed.
REQ-020 HOLD->COLLECT when out_ready=1; acc, error flag and digit counter clear in the same edge.
REQ-021 Latency SHALL be one cycle: out_valid asserts the cycle after the final digit is accepted.
REQ-022 out_ready while not in HOLD SHALL have no effect; in_valid during HOLD SHALL not be accepted.
REQ-023 Throughput SHALL be one digit per cycle in COLLECT; one bubble cycle per frame (HOLD) minimum.

Reset
REQ-024 rst_n low SHALL asynchronously force COLLECT, acc=0, counter=0, error flag=0, out_bin=0, out_err=0, out_valid=0.
REQ-025 in_ready SHALL read 1 while rst_n is low and immediately after release.
REQ-026 Reset mid-frame or during HOLD SHALL discard the partial or pending frame with no output.

Configuration
REQ-027 With macro EX3_ERR_CNT_EN defined, output port err_cnt (8 bits) SHALL count accepted invalid digits, saturating at 255, reset to 0 by rst_n only.
REQ-028 Without EX3_ERR_CNT_EN, err_cnt port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-029 Package ex3_pkg SHALL hold the FSM state typedef (COLLECT, HOLD), OUT_W=14, EX3_OFFSET=3, and invalid-code constants.
REQ-030 Sub-module ex3_digit_dec SHALL be purely combinational: 4-bit code in -> 4-bit digit and invalid flag out; instantiated once.

Verification
REQ-031 Digits 0100,1000,1100,0110 (in_last on fourth), out_ready=1 -> out_bin=1593, out_err=0, out_valid one cycle after fourth accept.
REQ-032 Digits 0111,0101 with in_last on second -> out_bin=42, out_err=0; next frame 0011 with in_last -> out_bin=0.
REQ-033 Digits 0100,1111,0100,0100 -> out_bin=1011, out_err=1; with EX3_ERR_CNT_EN, err_cnt increments by 1.
REQ-034 Frame 1100,1100,1100,1100 with out_ready=0 for 5 cycles -> out_bin=9999 held, in_ready=0 throughout; consumed on first out_ready=1, in_ready=1 the next cycle.
REQ-035 rst_n pulsed low after two accepted digits -> all outputs 0 immediately; next frame 0100 with in_last -> out_bin=1 with no residue.
REQ-036 With EX3_ERR_CNT_EN, 300 invalid digits (0000) -> err_cnt saturates at 255 and stays there.
